// File: rtl/abus_pkg.sv
// Shared A-bus definitions: capture FSM state encoding, default timing
// parameters and the fill value driven when a read response never arrives.
package abus_pkg;

    localparam int          ABUS_SYNC_STAGES    = 2;
    localparam int          ABUS_SETTLE_CYCLES  = 2;
    localparam int          ABUS_TIMEOUT_CYCLES = 255;
    localparam logic [15:0] ABUS_FILL_DATA      = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        REQUEST   = 3'd2,
        WAIT_DATA = 3'd3,
        DRIVE     = 3'd4,
        RELEASE   = 3'd5
    } abus_state_e;

endpackage

// File: rtl/abus_sync.sv
// Multi-flop synchronizer bank for asynchronous A-bus control inputs.
// Ports: clock, reset (async, active-high, flops reset to all ones),
// d (async input), q (synchronized output, DEPTH cycles later).
module abus_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage <= '1;
        end else begin
            stage <= {stage[DEPTH-2:0], d};
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/abus_cycle_capture.sv
// Saturn A-bus cycle capture: synchronizes bus strobes, issues exactly one
// bridge request per bus cycle and drives read data back onto the pads.
// Ports: clock/reset; abus_* pad side; req_*/rsp_* SDRAM bridge side.
module abus_cycle_capture
    import abus_pkg::*;
#(
    parameter int SYNC_STAGES    = ABUS_SYNC_STAGES,
    parameter int SETTLE_CYCLES  = ABUS_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = ABUS_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [24:0] abus_address,
    input  logic [2:0]  abus_chipselect,
    input  logic        abus_read,
    input  logic [1:0]  abus_writebyteenable_n,
    input  logic [15:0] abus_data_in,
    output logic [15:0] abus_data_out,
    output logic        abus_direction,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [24:0] req_address,
    output logic        req_cs1,
    output logic [1:0]  req_byteenable,
    output logic [15:0] req_writedata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_readdata
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW = $clog2(SYNC_STAGES + 2);

    abus_state_e state, next_state;

    logic [4:0]    sync_in, sync_out;
    logic [1:0]    s_cs;
    logic          s_rd;
    logic [1:0]    s_wbe_n;
    logic          unused_cs2;

    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [BW-1:0] boot_cnt;
    logic          aborted;

    logic rd_low, wr_low, cs_low, access, released, bus_idle;
    logic boot_check, boot_done, timeout_hit, latch_en;

    assign unused_cs2 = abus_chipselect[2];
    assign sync_in    = {abus_writebyteenable_n, abus_read,
                         abus_chipselect[1:0]};

    abus_sync #(
        .WIDTH(5),
        .DEPTH(SYNC_STAGES)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (sync_in),
        .q    (sync_out)
    );

    assign s_cs    = sync_out[1:0];
    assign s_rd    = sync_out[2];
    assign s_wbe_n = sync_out[4:3];

    assign rd_low   = ~s_rd;
    assign wr_low   = ~&s_wbe_n;
    assign cs_low   = ~&s_cs;
    assign access   = cs_low & (rd_low | wr_low);
    // the latched window's select or the read strobe going high ends a read
    assign released = s_rd | s_cs[req_cs1];
    assign bus_idle = (&s_cs) & s_rd & (&s_wbe_n);

    // synchronizers hold their reset value for SYNC_STAGES cycles; the
    // first trustworthy sample decides whether a cycle was already running
    assign boot_check  = (boot_cnt == BW'(SYNC_STAGES));
    assign boot_done   = (boot_cnt == BW'(SYNC_STAGES + 1));
    assign timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        next_state = state;
        latch_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (boot_check) begin
                    if (rd_low | wr_low) next_state = RELEASE;
                end else if (boot_done && access) begin
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (!access) begin
                    next_state = IDLE;
                end else if (settle_cnt == '0) begin
                    next_state = REQUEST;
                    latch_en   = 1'b1;
                end
            end
            REQUEST: begin
                if (req_ready) next_state = req_write ? RELEASE : WAIT_DATA;
            end
            WAIT_DATA: begin
                if (rsp_valid || timeout_hit)
                    next_state = (aborted || released) ? RELEASE : DRIVE;
            end
            DRIVE: begin
                if (released) next_state = RELEASE;
            end
            RELEASE: begin
                if (bus_idle) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            timeout_cnt    <= '0;
            boot_cnt       <= '0;
            aborted        <= 1'b0;
            req_valid      <= 1'b0;
            abus_direction <= 1'b0;
            abus_data_out  <= '0;
            req_write      <= 1'b0;
            req_address    <= '0;
            req_cs1        <= 1'b0;
            req_byteenable <= '0;
            req_writedata  <= '0;
        end else begin
            state          <= next_state;
            req_valid      <= (next_state == REQUEST);
            abus_direction <= (next_state == DRIVE);

            if (!boot_done) boot_cnt <= boot_cnt + BW'(1);

            if (state == IDLE && next_state == SETTLE)
                settle_cnt <= SW'(SETTLE_CYCLES - 1);
            else if (state == SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - SW'(1);

            if (state == WAIT_DATA) timeout_cnt <= timeout_cnt + TW'(1);
            else                    timeout_cnt <= '0;

            // a read given up mid-wait still consumes its response
            aborted <= (state == WAIT_DATA) && (aborted || released);

            if (latch_en) begin
                req_address    <= abus_address;
                req_cs1        <= s_cs[0];
                req_write      <= wr_low;
                req_byteenable <= wr_low ? ~s_wbe_n : 2'b11;
                if (wr_low) req_writedata <= abus_data_in;
            end

            if (state == WAIT_DATA && next_state == DRIVE)
                abus_data_out <= rsp_valid ? rsp_readdata : ABUS_FILL_DATA;
        end
    end

endmodule

// File: tb/tb_abus_cycle_capture.sv
// Self-checking bench for abus_cycle_capture: vector table of bus cycles,
// bridge model with expected-request scoreboard, and corner sequences.
module tb_abus_cycle_capture;
    import abus_pkg::*;

    localparam int SYNC = 2;
    localparam int TMO  = 255;

    logic        clock = 1'b0;
    logic        reset;
    logic [24:0] abus_address;
    logic [2:0]  abus_chipselect;
    logic        abus_read;
    logic [1:0]  abus_writebyteenable_n;
    logic [15:0] abus_data_in;
    logic [15:0] abus_data_out;
    logic        abus_direction;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [24:0] req_address;
    logic        req_cs1;
    logic [1:0]  req_byteenable;
    logic [15:0] req_writedata;
    logic        rsp_valid;
    logic [15:0] rsp_readdata;

    abus_cycle_capture #(
        .SYNC_STAGES(SYNC),
        .SETTLE_CYCLES(2),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .abus_address(abus_address),
        .abus_chipselect(abus_chipselect),
        .abus_read(abus_read),
        .abus_writebyteenable_n(abus_writebyteenable_n),
        .abus_data_in(abus_data_in),
        .abus_data_out(abus_data_out),
        .abus_direction(abus_direction),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_address(req_address),
        .req_cs1(req_cs1),
        .req_byteenable(req_byteenable),
        .req_writedata(req_writedata),
        .rsp_valid(rsp_valid),
        .rsp_readdata(rsp_readdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  cs;
        logic        rd_n;
        logic [1:0]  wbe_n;
        logic [24:0] addr;
        logic [15:0] wdata;
        int          rdy_dly;
        int          rsp_dly;
        logic [15:0] rsp_data;
        logic        exp_req;
        logic        exp_write;
        logic        exp_cs1;
        logic [1:0]  exp_be;
    } vec_t;

    typedef struct {
        logic        write;
        logic        cs1;
        logic [1:0]  be;
        logic [24:0] addr;
        logic [15:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[7];

    int n_cmp = 0;
    int n_bad = 0;

    int          cfg_rdy = 0;
    int          cfg_rsp = -1;
    logic [15:0] cfg_data = 16'h0;
    int          inj_req = 0;
    logic [15:0] inj_data = 16'h0;

    int cyc = 0;
    int xfer_cyc = 0;
    int xfer_cnt = 0;
    int valid_cnt = 0;
    int dir_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // bridge model: ready after cfg_rdy cycles of valid, response after
    // cfg_rsp cycles; payload scored against the expected-request queue
    initial begin : bridge
        int wait_cnt;
        int rsp_cd;
        int inj_done;
        wait_cnt = 0;
        rsp_cd = 0;
        inj_done = 0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_readdata = 16'h0;
        forever begin
            @(negedge clock);
            cyc++;
            if (abus_direction) dir_cnt++;
            rsp_valid = 1'b0;
            if (rsp_cd > 0) begin
                rsp_cd--;
                if (rsp_cd == 0) begin
                    rsp_valid = 1'b1;
                    rsp_readdata = cfg_data;
                end
            end
            if (inj_req != inj_done) begin
                inj_done = inj_req;
                rsp_valid = 1'b1;
                rsp_readdata = inj_data;
            end
            if (req_valid) begin
                valid_cnt++;
                req_ready = (wait_cnt >= cfg_rdy);
                if (!req_ready) wait_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    check("req_write", req_write, exp_q[0].write);
                    check("req_cs1", req_cs1, exp_q[0].cs1);
                    check("req_be", req_byteenable, exp_q[0].be);
                    check("req_addr", req_address, exp_q[0].addr);
                    if (exp_q[0].write)
                        check("req_wdata", req_writedata, exp_q[0].wdata);
                end
                if (req_ready) begin
                    xfer_cnt++;
                    xfer_cyc = cyc;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    if (!req_write && cfg_rsp > 0) rsp_cd = cfg_rsp;
                end
            end else begin
                req_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic bus_idle();
        abus_chipselect = 3'b111;
        abus_read = 1'b1;
        abus_writebyteenable_n = 2'b11;
    endtask

    task automatic wait_fall(input string name);
        int n;
        n = 0;
        abus_read = 1'b1;
        do begin
            tick();
            n++;
        end while (abus_direction && n < 20);
        check(name, n, SYNC + 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int x0, d0, n;
        exp_t e;
        x0 = xfer_cnt;
        d0 = dir_cnt;
        cfg_rdy = v.rdy_dly;
        cfg_rsp = v.rsp_dly;
        cfg_data = v.rsp_data;
        if (v.exp_req) begin
            e = '{v.exp_write, v.exp_cs1, v.exp_be, v.addr, v.wdata};
            exp_q.push_back(e);
        end
        abus_address = v.addr;
        abus_data_in = v.wdata;
        abus_chipselect = v.cs;
        abus_read = v.rd_n;
        abus_writebyteenable_n = v.wbe_n;
        if (v.exp_req && !v.exp_write) begin
            n = 0;
            while (!abus_direction && n < 100) begin
                tick();
                n++;
            end
            check($sformatf("v%0d_drive", idx), abus_direction, 1);
            check($sformatf("v%0d_rdata", idx), abus_data_out, v.rsp_data);
            wait_fall($sformatf("v%0d_fall", idx));
        end else if (v.exp_req) begin
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                tick();
                n++;
            end
            repeat (2) tick();
        end else begin
            repeat (20) tick();
        end
        bus_idle();
        repeat (8) tick();
        check($sformatf("v%0d_xfers", idx), xfer_cnt - x0,
              v.exp_req ? 1 : 0);
        check($sformatf("v%0d_pending", idx), exp_q.size(), 0);
        if (v.exp_write || !v.exp_req)
            check($sformatf("v%0d_nodrive", idx), dir_cnt - d0, 0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int x0, v0, d0, n;
        exp_t e;

        vecs[0] = '{3'b110, 1'b0, 2'b11, 25'h0001234, 16'h0000, 0, 5,
                    16'hBEEF, 1'b1, 1'b0, 1'b0, 2'b11};
        vecs[1] = '{3'b101, 1'b1, 2'b10, 25'h0000400, 16'h00A5, 4, -1,
                    16'h0000, 1'b1, 1'b1, 1'b1, 2'b01};
        vecs[2] = '{3'b100, 1'b0, 2'b11, 25'h1FFFFFF, 16'h0000, 1, 1,
                    16'h1234, 1'b1, 1'b0, 1'b0, 2'b11};
        vecs[3] = '{3'b101, 1'b1, 2'b00, 25'h00ABCDE, 16'h5AC3, 1, -1,
                    16'h0000, 1'b1, 1'b1, 1'b1, 2'b11};
        vecs[4] = '{3'b110, 1'b1, 2'b01, 25'h1000001, 16'hFF00, 0, -1,
                    16'h0000, 1'b1, 1'b1, 1'b0, 2'b10};
        vecs[5] = '{3'b101, 1'b0, 2'b11, 25'h0000000, 16'h0000, 2, 1,
                    16'h8001, 1'b1, 1'b0, 1'b1, 2'b11};
        vecs[6] = '{3'b011, 1'b0, 2'b11, 25'h0000010, 16'h0000, 0, 1,
                    16'h0000, 1'b0, 1'b0, 1'b0, 2'b00};

        reset = 1'b1;
        bus_idle();
        abus_address = '0;
        abus_data_in = '0;
        repeat (3) tick();
        check("rst_valid", req_valid, 0);
        check("rst_dir", abus_direction, 0);
        check("rst_dout", abus_data_out, 0);
        check("rst_write", req_write, 0);
        check("rst_addr", req_address, 0);
        check("rst_cs1", req_cs1, 0);
        check("rst_be", req_byteenable, 0);
        check("rst_wdata", req_writedata, 0);
        reset = 1'b0;
        repeat (6) tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // one-cycle read strobe: shorter than settle, no request
        x0 = xfer_cnt;
        v0 = valid_cnt;
        abus_address = 25'h0000777;
        abus_chipselect = 3'b110;
        tick();
        abus_read = 1'b0;
        tick();
        abus_read = 1'b1;
        repeat (10) tick();
        bus_idle();
        repeat (4) tick();
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_xfers", xfer_cnt - x0, 0);
        run_vec(vecs[0], 10);

        // no response: timeout fill, late response ignored
        cfg_rdy = 0;
        cfg_rsp = -1;
        e = '{1'b0, 1'b0, 2'b11, 25'h0100000, 16'h0};
        exp_q.push_back(e);
        x0 = xfer_cnt;
        abus_address = 25'h0100000;
        abus_chipselect = 3'b110;
        abus_read = 1'b0;
        n = 0;
        while (xfer_cnt == x0 && n < 50) begin
            tick();
            n++;
        end
        check("tmo_xfer", xfer_cnt - x0, 1);
        n = 0;
        while (!abus_direction && n < 400) begin
            tick();
            n++;
        end
        check("tmo_cycles", cyc - xfer_cyc, TMO + 1);
        check("tmo_fill", abus_data_out, 16'hFFFF);
        inj_data = 16'h1357;
        inj_req++;
        repeat (4) tick();
        check("tmo_late_data", abus_data_out, 16'hFFFF);
        check("tmo_late_dir", abus_direction, 1);
        wait_fall("tmo_fall");
        bus_idle();
        repeat (8) tick();
        check("tmo_xfers", xfer_cnt - x0, 1);

        // reset during WAIT_DATA with the read still held
        cfg_rsp = -1;
        e = '{1'b0, 1'b0, 2'b11, 25'h0055AA0, 16'h0};
        exp_q.push_back(e);
        x0 = xfer_cnt;
        abus_address = 25'h0055AA0;
        abus_chipselect = 3'b110;
        abus_read = 1'b0;
        n = 0;
        while (xfer_cnt == x0 && n < 50) begin
            tick();
            n++;
        end
        check("mid_xfer", xfer_cnt - x0, 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_valid", req_valid, 0);
        check("mid_rst_dir", abus_direction, 0);
        tick();
        reset = 1'b0;
        v0 = valid_cnt;
        d0 = dir_cnt;
        repeat (40) tick();
        check("post_rst_valid", valid_cnt - v0, 0);
        check("post_rst_dir", dir_cnt - d0, 0);
        bus_idle();
        repeat (8) tick();
        run_vec(vecs[0], 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/abus_cycle_capture.md
ABUS_CYCLE_CAPTURE -- requirements
Module: abus_cycle_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on every A-bus input (minimum 2).
REQ-002 Parameter SETTLE_CYCLES, default 2: clock cycles between strobe detection and address/data capture.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum wait for a read response before substituting 16'hFFFF.
REQ-004 clock  in  1  single system clock (116 MHz domain); every flop is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 abus_address  in  25  Saturn A-bus address, asynchronous.
REQ-007 abus_chipselect  in  3  active-low chip selects; only bits [1:0] are decoded and bit 2 is ignored.
REQ-008 abus_read  in  1  active-low read strobe, asynchronous.
REQ-009 abus_writebyteenable_n  in  2  active-low write strobes, [1] upper byte, [0] lower byte.
REQ-010 abus_data_in  in  16  data bus value sampled from the pads.
REQ-011 abus_data_out  out  16  read data presented to the pads.
REQ-012 abus_direction  out  1  1 = FPGA drives abus_data_out onto the bus.
REQ-013 req_valid / req_ready  out / in  1 / 1  request handshake toward the SDRAM bridge.
REQ-014 req_write  out  1  1 = write, 0 = read.
REQ-015 req_address  out  25  latched address; req_cs1  out  1  1 = CS1 window, 0 = CS0 window.
REQ-016 req_byteenable  out  2  active-high byte enables (the inverse of the latched write strobes; 2'b11 on reads).
REQ-017 req_writedata  out  16  latched write data.
REQ-018 rsp_valid / rsp_readdata  in / in  1 / 16  read response from the bridge, one-cycle pulse.

Function
REQ-019 The block SHALL pass chipselect[1:0], read, and writebyteenable_n through SYNC_STAGES flops; address and data are sampled unsynchronized only at the capture point.
REQ-020 An access SHALL start when synced CS0 or CS1 is low and either synced read or any synced write strobe is low; CS0 has priority if both selects are low.
REQ-021 The FSM states SHALL be IDLE, SETTLE, REQUEST, WAIT_DATA, DRIVE, RELEASE.
REQ-022 IDLE->SETTLE on access start; the settle counter loads SETTLE_CYCLES-1.
REQ-023 SETTLE->REQUEST when the counter reaches 0; address, cs1, direction-of-access, byteenable, and data (writes) SHALL be latched on that transition.
REQ-024 In REQUEST, req_valid SHALL be held at 1 with stable payload until req_ready is 1 (transfer on valid&ready); writes then go to RELEASE and reads go to WAIT_DATA.
REQ-025 WAIT_DATA->DRIVE on rsp_valid: abus_data_out <= rsp_readdata and abus_direction <= 1 on the next cycle.
REQ-026 If WAIT_DATA lasts TIMEOUT_CYCLES cycles without rsp_valid, the block SHALL go to DRIVE with abus_data_out = 16'hFFFF, and a late rsp_valid SHALL be ignored.
REQ-027 DRIVE->RELEASE when synced read or the selected CS goes high; abus_direction SHALL fall in the same cycle the release is detected.
REQ-028 RELEASE->IDLE only when synced CS[1:0] are both high and all strobes are high, so each bus cycle produces exactly one request.
REQ-029 Strobe released during SETTLE: the block SHALL return to IDLE with no request issued.
REQ-030 Read strobe released during WAIT_DATA: the response SHALL be awaited (or timed out) and discarded, abus_direction SHALL stay 0, and the FSM goes to RELEASE.
REQ-031 A write released during REQUEST SHALL still be committed, because its data is already latched.
REQ-032 abus_direction SHALL be 1 only in DRIVE.

Reset
REQ-033 On reset: FSM = IDLE, synchronizers = all ones (inactive), counters = 0, req_valid = 0, abus_direction = 0, abus_data_out = 0, and all req_* payload outputs = 0.
REQ-034 Reset asserted mid-access SHALL drop the access immediately; after reset releases, an access still held on the bus SHALL be ignored until RELEASE conditions are seen (the FSM enters RELEASE if any strobe is low on the first cycle after reset).

Structure
REQ-035 The state encoding, the SYNC/SETTLE/TIMEOUT defaults, and the 16'hFFFF fill value SHALL live in the shared A-bus package.
REQ-036 One sub-module, abus_sync (parameterised width and depth, reset value all ones), SHALL implement the synchronizers.

Verification
REQ-037 CS0 low, read low, address 0x0001234; bridge returns 0xBEEF after 5 cycles -> one read request with addr 0x0001234, cs1=0, be=11; DRIVE with data 0xBEEF; direction falls when read rises.
REQ-038 CS1 low, write_n=2'b10, data 0x00A5; req_ready held low for 4 cycles -> req_valid and payload stable, be=01, req_cs1=1, exactly one transfer.
REQ-039 Read with no response -> after 255 cycles the bus is driven with 0xFFFF; an rsp_valid injected afterwards has no effect.
REQ-040 Read strobe glitch of 1 cycle (shorter than settle) -> no req_valid and FSM back in IDLE.
REQ-041 Reset pulse during WAIT_DATA while read is held low -> direction stays 0, no new request until CS and read go high and then low again.
